pipe_ctrl: RTL

//  Central stall/flush sequencer for the in-order front-end pipeline registers (PC->IF, IF->ID, ...).

---
 rtl/pipe_ctrl_if.sv | 27 ++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stall/flush sequencer and the pipeline/PC generator.
// master = sequencer side, slave = pipeline side.
interface pipe_ctrl_if #(
  parameter int STAGE_NUM  = 5,
  parameter int ADDR_WIDTH = 32
);
  logic [STAGE_NUM-1:0]  stall_req;
  logic                  exc_valid;
  logic [ADDR_WIDTH-1:0] exc_pc;
  logic                  mispred_valid;
  logic [ADDR_WIDTH-1:0] mispred_pc;
  logic                  fetch_ready;
  logic [STAGE_NUM-1:0]  stall;
  logic [STAGE_NUM-1:0]  flush;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    input  stall_req, exc_valid, exc_pc, mispred_valid, mispred_pc, fetch_ready,
    output stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    output stall_req, exc_valid, exc_pc, mispred_valid, mispred_pc, fetch_ready,
    input  stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the in-order front end: backpressure, redirect flushes, pending redirect PC.
// Optional PIPE_CTRL_PERF_EN adds perf_stall_cycles / perf_flush_count counters.
module pipe_ctrl #(
  parameter int STAGE_NUM  = 5,
  parameter int BR_STAGE   = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_if.master       bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_count
`endif
);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  localparam logic [STAGE_NUM-1:0] ALL_MASK = '1;
  localparam logic [STAGE_NUM-1:0] BR_MASK  = ALL_MASK >> (STAGE_NUM - 1 - BR_STAGE);

  state_t                r_state;
  logic                  r_pend_exc;
  logic [ADDR_WIDTH-1:0] r_pend_pc;

  logic                  w_hold;
  logic                  w_take_exc;
  logic                  w_take_mis;
  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_req_pc;
  logic [STAGE_NUM-1:0]  w_flush;
  logic [STAGE_NUM-1:0]  w_stall_base;

  assign w_hold = (r_state == ST_HOLD);

  // A mispredict cannot displace an exception already waiting for fetch.
  always_comb begin
    w_take_exc = 1'b0;
    w_take_mis = 1'b0;
    if (bus.exc_valid) begin
      w_take_exc = 1'b1;
    end else if (bus.mispred_valid && !(w_hold && r_pend_exc)) begin
      w_take_mis = 1'b1;
    end
  end

  assign w_req    = w_take_exc | w_take_mis;
  assign w_req_pc = w_take_exc ? bus.exc_pc : bus.mispred_pc;
  assign w_flush  = w_take_exc ? ALL_MASK : (w_take_mis ? BR_MASK : '0);

  genvar gi;
  generate
    for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stall
      if (gi == 0) begin : g_pc
        assign w_stall_base[gi] = (|bus.stall_req[STAGE_NUM-1:gi]) | w_hold;
      end else begin : g_stage
        assign w_stall_base[gi] = |bus.stall_req[STAGE_NUM-1:gi];
      end
    end
  endgenerate

  // Outputs are combinational so a redirect reaches fetch in the request cycle.
  always_comb begin
    bus.stall          = '0;
    bus.flush          = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    if (!rst) begin
      bus.flush          = w_flush;
      bus.stall          = w_stall_base & ~w_flush;
      bus.redirect_valid = w_hold | (w_req & bus.fetch_ready);
      if (w_req && (w_hold || bus.fetch_ready)) begin
        bus.redirect_pc = w_req_pc;
      end else if (w_hold) begin
        bus.redirect_pc = r_pend_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pend_exc <= 1'b0;
      r_pend_pc  <= '0;
    end else begin
      if (w_req) begin
        r_pend_exc <= w_take_exc;
        r_pend_pc  <= w_req_pc;
      end
      case (r_state)
        ST_RUN: begin
          if (w_req && !bus.fetch_ready) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.fetch_ready) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (bus.stall[0]) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (|bus.flush) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`endif

endmodule
